// File: rtl/led_fade_seq.sv
// ---------------------------------------------------------------------------
// led_fade_seq
//
// Steps the R, G and B duty values of an external PWM block toward
// CPU-programmed targets. Each step writes all three channels, one per cycle,
// and then checks whether every channel has reached its target.
//
// Parameters
//   BITS          data width of the CPU bus and the PWM bus
//   ADDRESS_BITS  register address width on the CPU bus and the PWM bus
//
// Ports
//   CLK          clock; all state updates on its rising edge
//   RSTb         asynchronous active-low reset
//   ADDRESS      CPU register address
//   DATA_IN      CPU write data
//   DATA_OUT     CPU read data, combinational from ADDRESS
//   WR           CPU write strobe, one write per cycle while high
//   PWM_ADDRESS  PWM channel address (0=R, 1=G, 2=B)
//   PWM_DATA     duty value written to the PWM block
//   PWM_WR       PWM write strobe, one cycle per write
//
// Register map
//   0x0..0x2 TGT_R/G/B (RW)   0x3 STEP (RW)   0x4 PERIOD (RW)
//   0x5 CTRL (W: bit0 START, bit1 ABORT; reads 0)
//   0x6 STATUS (R: bit0 BUSY, bit1 DONE)   0x8..0xA CUR_R/G/B (R)
// ---------------------------------------------------------------------------
module led_fade_seq #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic [ADDRESS_BITS-1:0] ADDRESS,
    input  logic [BITS-1:0]         DATA_IN,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic                    WR,
    output logic [ADDRESS_BITS-1:0] PWM_ADDRESS,
    output logic [BITS-1:0]         PWM_DATA,
    output logic                    PWM_WR
);

    localparam logic [ADDRESS_BITS-1:0] A_TGT_R  = ADDRESS_BITS'(4'h0);
    localparam logic [ADDRESS_BITS-1:0] A_TGT_G  = ADDRESS_BITS'(4'h1);
    localparam logic [ADDRESS_BITS-1:0] A_TGT_B  = ADDRESS_BITS'(4'h2);
    localparam logic [ADDRESS_BITS-1:0] A_STEP   = ADDRESS_BITS'(4'h3);
    localparam logic [ADDRESS_BITS-1:0] A_PERIOD = ADDRESS_BITS'(4'h4);
    localparam logic [ADDRESS_BITS-1:0] A_CTRL   = ADDRESS_BITS'(4'h5);
    localparam logic [ADDRESS_BITS-1:0] A_STATUS = ADDRESS_BITS'(4'h6);
    localparam logic [ADDRESS_BITS-1:0] A_CUR_R  = ADDRESS_BITS'(4'h8);
    localparam logic [ADDRESS_BITS-1:0] A_CUR_G  = ADDRESS_BITS'(4'h9);
    localparam logic [ADDRESS_BITS-1:0] A_CUR_B  = ADDRESS_BITS'(4'hA);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_UPD_R = 3'd2;
    localparam logic [2:0] ST_UPD_G = 3'd3;
    localparam logic [2:0] ST_UPD_B = 3'd4;
    localparam logic [2:0] ST_CHECK = 3'd5;

    logic [2:0]              state_reg;
    logic [BITS-1:0]         tgt_reg [3];
    logic [BITS-1:0]         cur_reg [3];
    logic [BITS-1:0]         cur_next [3];
    logic [2:0]              chan_eq;
    logic [BITS-1:0]         step_reg;
    logic [BITS-1:0]         period_reg;
    logic [BITS-1:0]         cnt_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [ADDRESS_BITS-1:0] pwm_address_reg;
    logic [BITS-1:0]         pwm_data_reg;
    logic                    pwm_wr_reg;

    logic [BITS-1:0] step_eff;
    logic            ctrl_wr;
    logic            all_done;

    // A STEP of zero would stall the fade forever, so it behaves as one.
    assign step_eff = (step_reg == '0) ? BITS'(1) : step_reg;
    assign ctrl_wr  = WR && (ADDRESS == A_CTRL);
    assign all_done = &chan_eq;

    // Per-channel step toward target. The remaining gap is compared against
    // the step before adding/subtracting, so the result lands exactly on the
    // target instead of overshooting, and the sum can never wrap because it
    // is only formed when it stays at or below the target.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [BITS-1:0] up_gap;
        logic [BITS-1:0] dn_gap;

        assign up_gap       = tgt_reg[gi] - cur_reg[gi];
        assign dn_gap       = cur_reg[gi] - tgt_reg[gi];
        assign chan_eq[gi]  = (cur_reg[gi] == tgt_reg[gi]);
        assign cur_next[gi] =
            (cur_reg[gi] < tgt_reg[gi]) ?
                ((up_gap <= step_eff) ? tgt_reg[gi] : cur_reg[gi] + step_eff) :
            (cur_reg[gi] > tgt_reg[gi]) ?
                ((dn_gap <= step_eff) ? tgt_reg[gi] : cur_reg[gi] - step_eff) :
                cur_reg[gi];
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_reg       <= ST_IDLE;
            for (int i = 0; i < 3; i++) begin
                tgt_reg[i] <= '0;
                cur_reg[i] <= '0;
            end
            step_reg        <= '0;
            period_reg      <= '0;
            cnt_reg         <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            pwm_address_reg <= '0;
            pwm_data_reg    <= '0;
            pwm_wr_reg      <= 1'b0;
        end else begin
            pwm_wr_reg <= 1'b0;

            if (WR) begin
                case (ADDRESS)
                    A_TGT_R:  tgt_reg[0] <= DATA_IN;
                    A_TGT_G:  tgt_reg[1] <= DATA_IN;
                    A_TGT_B:  tgt_reg[2] <= DATA_IN;
                    A_STEP:   step_reg   <= DATA_IN;
                    A_PERIOD: period_reg <= DATA_IN;
                    default:  ;
                endcase
            end

            // ABORT beats START, and either one overrides whatever the FSM
            // would have done this cycle (including a pending channel update).
            if (ctrl_wr && DATA_IN[1]) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
            end else if (ctrl_wr && DATA_IN[0]) begin
                state_reg <= ST_WAIT;
                cnt_reg   <= period_reg;
                busy_reg  <= 1'b1;
                done_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: ;
                    ST_WAIT: begin
                        if (cnt_reg == '0) begin
                            state_reg <= ST_UPD_R;
                        end else begin
                            cnt_reg <= cnt_reg - BITS'(1);
                        end
                    end
                    ST_UPD_R: begin
                        cur_reg[0]      <= cur_next[0];
                        pwm_address_reg <= ADDRESS_BITS'(0);
                        pwm_data_reg    <= cur_next[0];
                        pwm_wr_reg      <= 1'b1;
                        state_reg       <= ST_UPD_G;
                    end
                    ST_UPD_G: begin
                        cur_reg[1]      <= cur_next[1];
                        pwm_address_reg <= ADDRESS_BITS'(1);
                        pwm_data_reg    <= cur_next[1];
                        pwm_wr_reg      <= 1'b1;
                        state_reg       <= ST_UPD_B;
                    end
                    ST_UPD_B: begin
                        cur_reg[2]      <= cur_next[2];
                        pwm_address_reg <= ADDRESS_BITS'(2);
                        pwm_data_reg    <= cur_next[2];
                        pwm_wr_reg      <= 1'b1;
                        state_reg       <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        if (all_done) begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ST_IDLE;
                        end else begin
                            cnt_reg   <= period_reg;
                            state_reg <= ST_WAIT;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        DATA_OUT = '0;
        case (ADDRESS)
            A_TGT_R:  DATA_OUT = tgt_reg[0];
            A_TGT_G:  DATA_OUT = tgt_reg[1];
            A_TGT_B:  DATA_OUT = tgt_reg[2];
            A_STEP:   DATA_OUT = step_reg;
            A_PERIOD: DATA_OUT = period_reg;
            A_STATUS: DATA_OUT = {{(BITS-2){1'b0}}, done_reg, busy_reg};
            A_CUR_R:  DATA_OUT = cur_reg[0];
            A_CUR_G:  DATA_OUT = cur_reg[1];
            A_CUR_B:  DATA_OUT = cur_reg[2];
            default:  DATA_OUT = '0;
        endcase
    end

    assign PWM_ADDRESS = pwm_address_reg;
    assign PWM_DATA    = pwm_data_reg;
    assign PWM_WR      = pwm_wr_reg;

endmodule

// File: tb/tb_led_fade_seq.sv
// ---------------------------------------------------------------------------
// tb_led_fade_seq
//
// Directed bench for led_fade_seq. A monitor logs every PWM write with the
// cycle it was visible in; each scenario task drives the CPU bus and compares
// the log and register reads against hand-computed values.
// ---------------------------------------------------------------------------
module tb_led_fade_seq;

    logic        CLK;
    logic        RSTb;
    logic [3:0]  ADDRESS;
    logic [15:0] DATA_IN;
    logic [15:0] DATA_OUT;
    logic        WR;
    logic [3:0]  PWM_ADDRESS;
    logic [15:0] PWM_DATA;
    logic        PWM_WR;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int wr_cyc = 0;

    int log_cyc [$];
    int log_addr[$];
    int log_data[$];

    led_fade_seq #(.BITS(16), .ADDRESS_BITS(4)) dut (
        .CLK         (CLK),
        .RSTb        (RSTb),
        .ADDRESS     (ADDRESS),
        .DATA_IN     (DATA_IN),
        .DATA_OUT    (DATA_OUT),
        .WR          (WR),
        .PWM_ADDRESS (PWM_ADDRESS),
        .PWM_DATA    (PWM_DATA),
        .PWM_WR      (PWM_WR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cycle <= cycle + 1;

    always @(negedge CLK) begin
        if (PWM_WR === 1'b1) begin
            log_cyc.push_back(cycle);
            log_addr.push_back(int'(PWM_ADDRESS));
            log_data.push_back(int'(PWM_DATA));
        end
    end

    task automatic step_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        log_cyc.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // One write per call; wr_cyc is the cycle in which WR was high.
    task automatic cpu_write(input logic [3:0] a, input logic [15:0] d);
        ADDRESS = a;
        DATA_IN = d;
        WR      = 1'b1;
        wr_cyc  = cycle;
        @(posedge CLK);
        #1;
        WR      = 1'b0;
        DATA_IN = 16'h0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [15:0] d);
        ADDRESS = a;
        #1;
        d = DATA_OUT;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        logic [15:0] st;
        ok = 1'b0;
        for (int k = 0; k < max_cycles; k++) begin
            cpu_read(4'h6, st);
            if (st[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
            step_cycle();
        end
    endtask

    task automatic test_reset();
        logic [15:0] v;
        RSTb = 1'b1; WR = 1'b0; ADDRESS = 4'h0; DATA_IN = 16'h0;
        #2 RSTb = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (PWM_WR !== 1'b0 || PWM_DATA !== 16'h0 || PWM_ADDRESS !== 4'h0) begin
            errors++;
            $display("FAIL reset_pwm: got wr=%b addr=%0d data=%h want 0/0/0", PWM_WR, PWM_ADDRESS, PWM_DATA);
        end
        for (int a = 0; a < 16; a++) begin
            cpu_read(4'(a), v);
            checks++;
            if (v !== 16'h0) begin
                errors++;
                $display("FAIL reset_reg_%0h: got %h want 0000", a, v);
            end
        end
        @(negedge CLK);
        RSTb = 1'b1;
        step_cycle();
        $display("reset: released, errors=%0d", errors);
    endtask

    task automatic test_regs();
        logic [15:0] v;
        cpu_write(4'h0, 16'h1234);
        cpu_read(4'h0, v);
        checks++;
        if (v !== 16'h1234) begin errors++; $display("FAIL tgt_r_rw: got %h want 1234", v); end
        cpu_write(4'h3, 16'h00A5);
        cpu_read(4'h3, v);
        checks++;
        if (v !== 16'h00A5) begin errors++; $display("FAIL step_rw: got %h want 00a5", v); end
        cpu_write(4'h4, 16'h0777);
        cpu_read(4'h4, v);
        checks++;
        if (v !== 16'h0777) begin errors++; $display("FAIL period_rw: got %h want 0777", v); end
        cpu_write(4'h8, 16'h5555);
        cpu_read(4'h8, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL cur_r_ro: got %h want 0000", v); end
        cpu_write(4'h6, 16'hFFFC);
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL status_ro: got %h want 0000", v); end
        cpu_write(4'h7, 16'hBEEF);
        cpu_read(4'h7, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL unmapped_7: got %h want 0000", v); end
        cpu_read(4'h5, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL ctrl_reads_0: got %h want 0000", v); end
        cpu_write(4'h0, 16'h0);
        $display("regs: done, errors=%0d", errors);
    endtask

    // TGT_R=10 STEP=4 PERIOD=2: R = 4, 8, 10; step k channel c at wr+5+7k+c.
    task automatic test_basic_fade();
        logic [15:0] v;
        bit ok;
        int exp_r [3] = '{4, 8, 10};
        cpu_write(4'h0, 16'd10);
        cpu_write(4'h1, 16'd0);
        cpu_write(4'h2, 16'd0);
        cpu_write(4'h3, 16'd4);
        cpu_write(4'h4, 16'd2);
        clear_log();
        cpu_write(4'h5, 16'h1);
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h1) begin errors++; $display("FAIL basic_busy: got %h want 0001", v); end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: got busy want idle"); end
        repeat (10) step_cycle();
        checks++;
        if (log_cyc.size() !== 9) begin
            errors++;
            $display("FAIL basic_count: got %0d writes want 9", log_cyc.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                automatic int s = i / 3;
                automatic int c = i % 3;
                automatic int ed = (c == 0) ? exp_r[s] : 0;
                automatic int ec = wr_cyc + 5 + 7 * s + c;
                checks++;
                if (log_addr[i] !== c || log_data[i] !== ed || log_cyc[i] !== ec) begin
                    errors++;
                    $display("FAIL basic_wr%0d: got a=%0d d=%0d cyc=%0d want a=%0d d=%0d cyc=%0d",
                             i, log_addr[i], log_data[i], log_cyc[i], c, ed, ec);
                end
            end
        end
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h2) begin errors++; $display("FAIL basic_done: got %h want 0002", v); end
        cpu_read(4'h8, v);
        checks++;
        if (v !== 16'd10) begin errors++; $display("FAIL basic_cur_r: got %0d want 10", v); end
        $display("basic_fade: %0d writes, errors=%0d", log_cyc.size(), errors);
    endtask

    // CUR_R=10 -> TGT_R=0 with STEP=FFFF: one step, clamped to 0.
    task automatic test_decrease_clamp();
        logic [15:0] v;
        bit ok;
        cpu_write(4'h0, 16'd0);
        cpu_write(4'h3, 16'hFFFF);
        cpu_write(4'h4, 16'd1);
        clear_log();
        cpu_write(4'h5, 16'h1);
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h1) begin errors++; $display("FAIL clamp_done_cleared: got %h want 0001", v); end
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clamp_timeout: got busy want idle"); end
        repeat (5) step_cycle();
        checks++;
        if (log_cyc.size() !== 3 || log_addr[0] !== 0 || log_data[0] !== 0) begin
            errors++;
            $display("FAIL clamp_r: got n=%0d first=%0d want n=3 R=0",
                     log_cyc.size(), (log_data.size() > 0) ? log_data[0] : -1);
        end
        cpu_read(4'h8, v);
        checks++;
        if (v !== 16'd0) begin errors++; $display("FAIL clamp_cur_r: got %h want 0000", v); end
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h2) begin errors++; $display("FAIL clamp_done: got %h want 0002", v); end
        $display("decrease_clamp: %0d writes, errors=%0d", log_cyc.size(), errors);
    endtask

    // PERIOD=0: writes at N+3,4,5 then N+8,9,10 then N+13,14,15.
    task automatic test_timing();
        bit ok;
        int exp_off [9] = '{3, 4, 5, 8, 9, 10, 13, 14, 15};
        cpu_write(4'h0, 16'd3);
        cpu_write(4'h3, 16'd1);
        cpu_write(4'h4, 16'd0);
        clear_log();
        cpu_write(4'h5, 16'h1);
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timing_timeout: got busy want idle"); end
        repeat (5) step_cycle();
        checks++;
        if (log_cyc.size() !== 9) begin
            errors++;
            $display("FAIL timing_count: got %0d writes want 9", log_cyc.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                automatic int ec = wr_cyc + exp_off[i];
                automatic int ed = (i % 3 == 0) ? (i / 3 + 1) : 0;
                checks++;
                if (log_cyc[i] !== ec || log_addr[i] !== i % 3 || log_data[i] !== ed) begin
                    errors++;
                    $display("FAIL timing_wr%0d: got cyc=%0d a=%0d d=%0d want cyc=%0d a=%0d d=%0d",
                             i, log_cyc[i], log_addr[i], log_data[i], ec, i % 3, ed);
                end
            end
        end
        $display("timing: %0d writes, errors=%0d", log_cyc.size(), errors);
    endtask

    // CUR=(3,0,0), TGT_G=FFFF, STEP=8000: G = 8000 then FFFF.
    task automatic test_near_max();
        logic [15:0] v;
        bit ok;
        int exp_d [6] = '{3, 'h8000, 0, 3, 'hFFFF, 0};
        cpu_write(4'h1, 16'hFFFF);
        cpu_write(4'h3, 16'h8000);
        cpu_write(4'h4, 16'd1);
        clear_log();
        cpu_write(4'h5, 16'h1);
        wait_idle(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL nearmax_timeout: got busy want idle"); end
        repeat (5) step_cycle();
        checks++;
        if (log_cyc.size() !== 6) begin
            errors++;
            $display("FAIL nearmax_count: got %0d writes want 6", log_cyc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (log_data[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL nearmax_wr%0d: got %h want %h", i, log_data[i], exp_d[i]);
                end
            end
        end
        cpu_read(4'h9, v);
        checks++;
        if (v !== 16'hFFFF) begin errors++; $display("FAIL nearmax_cur_g: got %h want ffff", v); end
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h2) begin errors++; $display("FAIL nearmax_done: got %h want 0002", v); end
        $display("near_max: %0d writes, errors=%0d", log_cyc.size(), errors);
    endtask

    task automatic test_abort();
        logic [15:0] v;
        cpu_write(4'h0, 16'd100);
        cpu_write(4'h3, 16'd1);
        cpu_write(4'h4, 16'd20);
        clear_log();
        cpu_write(4'h5, 16'h1);
        repeat (5) step_cycle();
        cpu_write(4'h5, 16'h2);
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL abort_status: got %h want 0000", v); end
        repeat (40) step_cycle();
        checks++;
        if (log_cyc.size() !== 0) begin
            errors++;
            $display("FAIL abort_no_pwm: got %0d writes want 0", log_cyc.size());
        end
        cpu_read(4'h8, v);
        checks++;
        if (v !== 16'd3) begin errors++; $display("FAIL abort_cur_r: got %0d want 3", v); end
        cpu_write(4'h5, 16'h3);
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL abort_start_both: got %h want 0000", v); end
        repeat (10) step_cycle();
        checks++;
        if (log_cyc.size() !== 0) begin
            errors++;
            $display("FAIL abort_both_no_pwm: got %0d writes want 0", log_cyc.size());
        end
        $display("abort: errors=%0d", errors);
    endtask

    // Restart in WAIT moves the first R write to N1+7; ABORT during UPD_B
    // suppresses the B write.
    task automatic test_back_to_back();
        logic [15:0] v;
        int n1;
        cpu_write(4'h4, 16'd4);
        clear_log();
        cpu_write(4'h5, 16'h1);
        repeat (3) step_cycle();
        cpu_write(4'h5, 16'h1);
        n1 = wr_cyc;
        for (int k = 0; k < 30 && log_cyc.size() == 0; k++) step_cycle();
        checks++;
        if (log_cyc.size() == 0) begin
            errors++;
            $display("FAIL restart_timeout: got no write want R at cycle %0d", n1 + 7);
        end else if (log_cyc[0] !== n1 + 7 || log_addr[0] !== 0 || log_data[0] !== 4) begin
            errors++;
            $display("FAIL restart_first: got cyc=%0d a=%0d d=%0d want cyc=%0d a=0 d=4",
                     log_cyc[0], log_addr[0], log_data[0], n1 + 7);
        end
        cpu_write(4'h5, 16'h2);
        repeat (20) step_cycle();
        checks++;
        if (log_cyc.size() !== 2) begin
            errors++;
            $display("FAIL abort_in_upd: got %0d writes want 2", log_cyc.size());
        end
        cpu_read(4'h8, v);
        checks++;
        if (v !== 16'd4) begin errors++; $display("FAIL restart_cur_r: got %0d want 4", v); end
        $display("back_to_back: %0d writes, errors=%0d", log_cyc.size(), errors);
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        cpu_write(4'h2, 16'd50);
        cpu_write(4'h4, 16'd0);
        cpu_write(4'h5, 16'h1);
        step_cycle();
        step_cycle();
        #2;
        RSTb = 1'b0;
        clear_log();
        #1;
        checks++;
        if (PWM_WR !== 1'b0) begin errors++; $display("FAIL rstmid_pwm_wr: got %b want 0", PWM_WR); end
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL rstmid_status: got %h want 0000", v); end
        cpu_read(4'h9, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL rstmid_cur_g: got %h want 0000", v); end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RSTb = 1'b1;
        step_cycle();
        cpu_read(4'h8, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL rstmid_cur_r: got %h want 0000", v); end
        repeat (10) step_cycle();
        checks++;
        if (log_cyc.size() !== 0) begin
            errors++;
            $display("FAIL rstmid_no_pwm: got %0d writes want 0", log_cyc.size());
        end
        cpu_read(4'h6, v);
        checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL rstmid_idle: got %h want 0000", v); end
        $display("reset_mid: errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic_fade();
        test_decrease_clamp();
        test_timing();
        test_near_max();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_fade_seq.md
LED_FADE_SEQ -- requirements
Module: led_fade_seq

Interface
REQ-001 SHALL have parameter BITS, default 16, meaning the data width of the CPU bus and the PWM bus.
REQ-002 SHALL have parameter ADDRESS_BITS, default 4, meaning the register address width on the CPU bus and the PWM bus.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTb, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port ADDRESS, input, ADDRESS_BITS: CPU register address.
REQ-006 SHALL have port DATA_IN, input, BITS: CPU write data.
REQ-007 SHALL have port DATA_OUT, output, BITS: CPU read data, combinational from ADDRESS.
REQ-008 SHALL have port WR, input, 1 bit: CPU write strobe, one write per cycle while high.
REQ-009 SHALL have port PWM_ADDRESS, output, ADDRESS_BITS: RGB PWM channel address (0=R, 1=G, 2=B).
REQ-010 SHALL have port PWM_DATA, output, BITS: duty value written to the PWM block.
REQ-011 SHALL have port PWM_WR, output, 1 bit: write strobe to the PWM block, one cycle per write.

Function
REQ-012 SHALL decode CPU registers: 0x0/0x1/0x2 TGT_R/G/B (RW); 0x3 STEP (RW); 0x4 PERIOD (RW); 0x5 CTRL (W: bit0 START, bit1 ABORT, both self-clearing); 0x6 STATUS (R: bit0 BUSY, bit1 DONE, others 0); 0x8/0x9/0xA CUR_R/G/B (R).
REQ-013 SHALL return 0 on DATA_OUT for unmapped addresses and for CTRL; writes to read-only or unmapped addresses are ignored.
REQ-014 SHALL implement FSM states IDLE, WAIT, UPD_R, UPD_G, UPD_B, CHECK.
REQ-015 IDLE: on a CTRL write with START=1 and ABORT=0, load the wait counter with PERIOD, clear DONE, set BUSY, and go to WAIT.
REQ-016 WAIT: when the counter is 0, go to UPD_R; otherwise decrement. WAIT lasts PERIOD+1 cycles, so PERIOD=0 gives one cycle.
REQ-017 UPD_x: step CUR_x toward TGT_x and go to the next state (R->G->B->CHECK).
- If CUR<TGT: CUR += min(S, TGT-CUR).
- If CUR>TGT: CUR -= min(S, CUR-TGT).
- Otherwise: unchanged.
- S = STEP, with STEP=0 treated as 1.
REQ-018 Step arithmetic SHALL never overflow or underflow BITS and SHALL never overshoot the target.
REQ-019 Each UPD_x SHALL register PWM_ADDRESS=x, PWM_DATA=new CUR_x, PWM_WR=1, visible the cycle after UPD_x; PWM_WR=0 in all other cycles.
REQ-020 All three channels SHALL be written every step, even when unchanged.
REQ-021 CHECK: if CUR_R/G/B all equal TGT_R/G/B, set DONE, clear BUSY, and go to IDLE; else reload the counter with PERIOD and go to WAIT.
REQ-022 Step cadence SHALL be PERIOD+5 cycles. After a START write accepted in cycle N, the R/G/B writes appear in cycles N+PERIOD+3 / +4 / +5.
REQ-023 START while BUSY SHALL restart the timing: counter reloaded, state WAIT, DONE cleared, CUR values retained.
REQ-024 ABORT (with or without START) SHALL have priority: go to IDLE, clear BUSY, leave DONE and CUR unchanged, and issue no further PWM writes.
REQ-025 TGT, STEP, and PERIOD writes while BUSY SHALL take effect at the next UPD or counter reload that samples them.

Reset
REQ-026 While RSTb=0:
- All registers, CUR, DONE, BUSY, the counter, PWM_ADDRESS, PWM_DATA, and PWM_WR are 0.
- The state is IDLE.
REQ-027 Reset asserted mid-fade SHALL abort immediately with no further PWM_WR after the assertion edge. After release, the block stays in IDLE until START.

Verification
REQ-028 Basic fade: TGT_R=10, STEP=4, PERIOD=2, START -> PWM writes R=4,8,10 on successive steps; G and B written as 0; DONE=1, BUSY=0 after the third CHECK.
REQ-029 Decreasing fade with clamp: CUR_R=10, TGT_R=0, STEP=0xFFFF -> single step writes R=0; no underflow; DONE=1.
REQ-030 Timing: PERIOD=0, START in cycle N -> PWM_WR high in cycles N+3, N+4, N+5 with addresses 0, 1, 2; next step's R write in cycle N+8.
REQ-031 Abort: ABORT written during WAIT -> BUSY=0 next cycle, no PWM_WR ever after, CUR unchanged.
REQ-032 Near-max targets: TGT_G=0xFFFF, STEP=0x8000 -> G writes 0x8000, then 0xFFFF, then DONE.
REQ-033 Reset mid-fade: RSTb low asynchronously during UPD_G -> PWM_WR=0 and all status reads 0; DATA_OUT at 0x8 reads 0 after release.
